// File: rtl/alu_share_ctrl_pkg.sv
// Shared ALU definitions: widths, opcode constants, flag bit positions and controller state encoding.
// Used by the share controller, its arbiter, the ALU and the bench.
package alu_defs;

    localparam int W   = 6;
    localparam int OPW = 4;

    localparam logic [OPW-1:0] OP_ILL = 4'b0001;
    localparam logic [OPW-1:0] OP_ADD = 4'b1010;
    localparam logic [OPW-1:0] OP_SUB = 4'b1011;
    localparam logic [OPW-1:0] OP_XOR = 4'b1101;
    localparam logic [OPW-1:0] OP_AND = 4'b1110;
    localparam logic [OPW-1:0] OP_OR  = 4'b1111;

    // Bit positions inside the {BAF,ZF,IOF} flag vector
    localparam int FLAG_BAF = 2;
    localparam int FLAG_ZF  = 1;
    localparam int FLAG_IOF = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } share_state_t;

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, pointer register
// that moves to the other requester only when the served transaction completes.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       done,
    input  logic       done_id,
    output logic [1:0] gnt
);

    logic ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (done) begin
            ptr <= ~done_id;
        end
    end

    always_comb begin
        gnt = 2'b00;
        if (ptr == 1'b0) begin
            if (req[0])      gnt = 2'b01;
            else if (req[1]) gnt = 2'b10;
        end else begin
            if (req[1])      gnt = 2'b10;
            else if (req[0]) gnt = 2'b01;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Two-requester front end for the shared combinational ALU: arbitrates, registers
// operands/opcode, waits one settle cycle, then holds the result until the grantee takes it.
module alu_share_ctrl
    import alu_defs::*;
(
    input  logic           clk,
    input  logic           rst,

    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [OPW-1:0] req0_op,
    input  logic [W-1:0]   req0_x,
    input  logic [W-1:0]   req0_y,

    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [OPW-1:0] req1_op,
    input  logic [W-1:0]   req1_x,
    input  logic [W-1:0]   req1_y,

    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic           rsp1_valid,
    input  logic           rsp1_ready,
    output logic [W-1:0]   rsp_z,
    output logic [2:0]     rsp_flags,
    output logic           rsp_err,

    output logic [W-1:0]   alu_x,
    output logic [W-1:0]   alu_y,
    output logic [OPW-1:0] alu_op,
    input  logic [W-1:0]   alu_z,
    input  logic           alu_baf,
    input  logic           alu_zf,
    input  logic           alu_iof,

    output logic           busy
);

    share_state_t   state;
    logic           grantee;
    logic [1:0]     gnt;
    logic [1:0]     arb_req;
    logic           accept;
    logic           rsp_hs;
    logic [OPW-1:0] sel_op;
    logic [W-1:0]   sel_x;
    logic [W-1:0]   sel_y;

    // Requests are only visible to the arbiter while idle, so nobody is accepted mid-op
    assign arb_req = (state == ST_IDLE) ? {req1_valid, req0_valid} : 2'b00;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .done    (rsp_hs),
        .done_id (grantee),
        .gnt     (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign accept     = |gnt;

    assign sel_op = gnt[1] ? req1_op : req0_op;
    assign sel_x  = gnt[1] ? req1_x  : req0_x;
    assign sel_y  = gnt[1] ? req1_y  : req0_y;

    assign rsp_hs = (state == ST_RESP) && (grantee ? rsp1_ready : rsp0_ready);
    assign busy   = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            grantee    <= 1'b0;
            alu_x      <= '0;
            alu_y      <= '0;
            alu_op     <= '0;
            rsp_z      <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        grantee <= gnt[1];
                        // Illegal opcode never reaches the ALU; answer with an error immediately
                        if (sel_op == OP_ILL) begin
                            rsp_z      <= '0;
                            rsp_flags  <= '0;
                            rsp_err    <= 1'b1;
                            rsp0_valid <= gnt[0];
                            rsp1_valid <= gnt[1];
                            state      <= ST_RESP;
                        end else begin
                            alu_x  <= sel_x;
                            alu_y  <= sel_y;
                            alu_op <= sel_op;
                            state  <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    rsp_z      <= alu_z;
                    rsp_flags  <= {alu_baf, alu_zf, alu_iof};
                    rsp_err    <= 1'b0;
                    rsp0_valid <= ~grantee;
                    rsp1_valid <= grantee;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_hs) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a small behavioural ALU attached to the alu_* ports.
module tb_alu_share_ctrl;
    import alu_defs::*;

    logic           clk = 1'b0;
    logic           rst;
    logic           req0_valid, req0_ready, req1_valid, req1_ready;
    logic [OPW-1:0] req0_op, req1_op, alu_op;
    logic [W-1:0]   req0_x, req0_y, req1_x, req1_y;
    logic           rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [W-1:0]   rsp_z, alu_x, alu_y, alu_z;
    logic [2:0]     rsp_flags;
    logic           rsp_err, alu_baf, alu_zf, alu_iof, busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Stand-in ALU: baf mirrors x[5], iof mirrors y[0], zf flags a zero result
    always_comb begin
        alu_z = '0;
        case (alu_op)
            OP_ADD:  alu_z = alu_x + alu_y;
            OP_SUB:  alu_z = alu_x - alu_y;
            OP_XOR:  alu_z = alu_x ^ alu_y;
            OP_AND:  alu_z = alu_x & alu_y;
            OP_OR:   alu_z = alu_x | alu_y;
            default: alu_z = '0;
        endcase
        alu_baf = alu_x[5];
        alu_iof = alu_y[0];
        alu_zf  = (alu_z == '0);
    end

    alu_share_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_z      (rsp_z),
        .rsp_flags  (rsp_flags),
        .rsp_err    (rsp_err),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_op     (alu_op),
        .alu_z      (alu_z),
        .alu_baf    (alu_baf),
        .alu_zf     (alu_zf),
        .alu_iof    (alu_iof),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 0; req0_op = '0; req0_x = '0; req0_y = '0;
        req1_valid = 0; req1_op = '0; req1_x = '0; req1_y = '0;
        rsp0_ready = 0; rsp1_ready = 0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp_z", rsp_z, 0);
        tick();
        rst = 1'b0;

        // Test 1: single ADD from requester 0
        req0_valid = 1; req0_op = 4'b1010; req0_x = 6'b101101; req0_y = 6'b000011;
        #1;
        chk("t1_ready", req0_ready, 1);
        tick();
        req0_valid = 0;
        #1;
        chk("t1_ready_pulse", req0_ready, 0);
        chk("t1_exec_op", alu_op, 4'b1010);
        chk("t1_exec_x", alu_x, 6'b101101);
        chk("t1_busy", busy, 1);
        chk("t1_no_early_rsp", rsp0_valid, 0);
        tick();
        chk("t1_rsp0_valid", rsp0_valid, 1);
        chk("t1_rsp1_valid", rsp1_valid, 0);
        chk("t1_rsp_z", rsp_z, 6'b110000);
        chk("t1_flags", rsp_flags, 3'b101);
        chk("t1_err", rsp_err, 0);
        rsp0_ready = 1;
        tick();
        rsp0_ready = 0;
        chk("t1_done_valid", rsp0_valid, 0);
        chk("t1_done_busy", busy, 0);

        // Fresh pointer for the simultaneous-request test
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Test 2: simultaneous XOR/AND, pointer at 0
        req0_valid = 1; req0_op = 4'b1101; req0_x = 6'b111000; req0_y = 6'b001110;
        req1_valid = 1; req1_op = 4'b1110; req1_x = 6'b111000; req1_y = 6'b001110;
        #1;
        chk("t2_r0_ready", req0_ready, 1);
        chk("t2_r1_ready", req1_ready, 0);
        tick();
        req0_valid = 0;
        #1;
        chk("t2_r1_blocked", req1_ready, 0);
        tick();
        chk("t2_rsp0_valid", rsp0_valid, 1);
        chk("t2_rsp1_idle", rsp1_valid, 0);
        chk("t2_xor_z", rsp_z, 6'b110110);
        chk("t2_xor_flags", rsp_flags, 3'b100);
        rsp0_ready = 1;
        tick();
        rsp0_ready = 0;
        req0_valid = 1;
        #1;
        chk("t2_repeat_r1_ready", req1_ready, 1);
        chk("t2_repeat_r0_ready", req0_ready, 0);
        tick();
        req1_valid = 0;
        #1;
        chk("t2_and_op", alu_op, 4'b1110);
        tick();
        chk("t2_rsp1_valid", rsp1_valid, 1);
        chk("t2_rsp0_idle", rsp0_valid, 0);
        chk("t2_and_z", rsp_z, 6'b001000);
        rsp1_ready = 1;
        tick();
        rsp1_ready = 0;
        #1;
        chk("t2_r0_after", req0_ready, 1);
        tick();
        req0_valid = 0;
        tick();
        chk("t2_third_z", rsp_z, 6'b110110);
        rsp0_ready = 1;
        tick();
        rsp0_ready = 0;

        // Test 3: illegal opcode from requester 1 (pointer now 1)
        req1_valid = 1; req1_op = 4'b0001; req1_x = 6'b010101; req1_y = 6'b000000;
        #1;
        chk("t3_ready", req1_ready, 1);
        tick();
        req1_valid = 0;
        chk("t3_rsp1_valid", rsp1_valid, 1);
        chk("t3_rsp0_idle", rsp0_valid, 0);
        chk("t3_err", rsp_err, 1);
        chk("t3_z", rsp_z, 0);
        chk("t3_flags", rsp_flags, 0);
        chk("t3_alu_op_kept", alu_op, 4'b1101);
        rsp0_ready = 1;
        tick();
        rsp0_ready = 0;
        chk("t3_wrong_ready_ignored", rsp1_valid, 1);
        rsp1_ready = 1;
        tick();
        rsp1_ready = 0;
        chk("t3_done", busy, 0);

        // Test 4/5: SUB with stalled response, competing req1, operand changed mid-EXEC
        req0_valid = 1; req0_op = 4'b1011; req0_x = 6'b010101; req0_y = 6'b000101;
        req1_valid = 1; req1_op = 4'b1111; req1_x = 6'b000011; req1_y = 6'b110000;
        #1;
        chk("t4_r0_ready", req0_ready, 1);
        chk("t4_r1_ready", req1_ready, 0);
        tick();
        req0_valid = 0; req0_x = 6'b000000;
        #1;
        chk("t5_latched_x", alu_x, 6'b010101);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", rsp0_valid, 1);
            chk("t4_hold_z", rsp_z, 6'b010000);
            chk("t4_hold_r1", req1_ready, 0);
            tick();
        end
        chk("t4_flags", rsp_flags, 3'b001);
        rsp0_ready = 1;
        #1;
        chk("t4_r1_still_blocked", req1_ready, 0);
        tick();
        rsp0_ready = 0;
        #1;
        chk("t4_r1_granted", req1_ready, 1);
        tick();
        req1_valid = 0;

        // Test 6: asynchronous reset in the middle of EXEC
        chk("t6_pre_busy", busy, 1);
        chk("t6_pre_op", alu_op, 4'b1111);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_alu_op", alu_op, 0);
        chk("t6_alu_x", alu_x, 0);
        chk("t6_rsp_z", rsp_z, 0);
        chk("t6_rsp1_valid", rsp1_valid, 0);
        tick();
        tick();
        chk("t6_no_rsp", rsp1_valid, 0);
        rst = 1'b0;
        req0_valid = 1; req1_valid = 1;
        #1;
        chk("t6_ptr_r0", req0_ready, 1);
        chk("t6_ptr_r1", req1_ready, 0);
        req0_valid = 0; req1_valid = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
